ahb_lite_seven_seg: RTL and testbench

- AHB-Lite slave that turns CPU writes into a multiplexed 4-digit seven-segment display.
- Sits on the mipsfpga_sys AHB bus as a responder to the core's initiator port (HADDR/HWDATA/HWRITE out, HRDATA back).
- Drives the board seg/an pins, which are currently tied off at the board top.
- Holds a 16-bit hex value plus a control register, both read-back capable, and scans the digits with a programmable refresh counter.

---
 rtl/ahb_lite_seven_seg.sv | 144 ++++++++++++++
 tb/tb_ahb_lite_seven_seg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_seven_seg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : ahb_lite_seven_seg                                             |
// | Function : AHB-Lite slave driving a multiplexed 4-digit 7-segment display |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module ahb_lite_seven_seg #(
    parameter int SCAN_CYCLES = 100000,
    parameter int CNT_W       = 20
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    localparam logic [CNT_W-1:0] c_CNT_MAX   = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [1:0]       c_ADDR_HEX  = 2'd0;
    localparam logic [1:0]       c_ADDR_CTRL = 2'd1;

    logic             r_valid;
    logic             r_write;
    logic [1:0]       r_addr;
    logic [15:0]      r_hex;
    logic [3:0]       r_en;
    logic [3:0]       r_dp;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [7:0]       r_seg;
    logic [3:0]       r_an;

    logic             w_accept;
    logic             w_wr_en;
    logic [3:0]       w_nib;
    logic [6:0]       w_seg7;
    logic             w_unused;

    assign w_accept = HSEL & HREADY & HTRANS[1];
    assign w_wr_en  = r_valid & r_write;
    assign w_nib    = r_hex[{r_idx, 2'b00} +: 4];
    assign w_unused = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

    // Address phase capture and data-phase register write
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= 2'd0;
            r_hex   <= 16'h0000;
            r_en    <= 4'hF;
            r_dp    <= 4'h0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_write <= HWRITE;
                r_addr  <= HADDR[3:2];
            end else if (HREADY) begin
                r_valid <= 1'b0;
            end
            if (w_wr_en) begin
                case (r_addr)
                    c_ADDR_HEX:  r_hex        <= HWDATA[15:0];
                    c_ADDR_CTRL: {r_dp, r_en} <= HWDATA[7:0];
                    default:     ;
                endcase
            end
        end
    end

    always_comb begin
        HRDATA = 32'h0000_0000;
        if (r_valid && !r_write) begin
            case (r_addr)
                c_ADDR_HEX:  HRDATA = {16'h0000, r_hex};
                c_ADDR_CTRL: HRDATA = {24'h000000, r_dp, r_en};
                default:     HRDATA = 32'h0000_0000;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    // Free-running digit scan, independent of bus traffic
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_seg7 = 7'b1111111;
        case (w_nib)
            4'h0: w_seg7 = 7'b1000000;
            4'h1: w_seg7 = 7'b1111001;
            4'h2: w_seg7 = 7'b0100100;
            4'h3: w_seg7 = 7'b0110000;
            4'h4: w_seg7 = 7'b0011001;
            4'h5: w_seg7 = 7'b0010010;
            4'h6: w_seg7 = 7'b0000010;
            4'h7: w_seg7 = 7'b1111000;
            4'h8: w_seg7 = 7'b0000000;
            4'h9: w_seg7 = 7'b0010000;
            4'hA: w_seg7 = 7'b0001000;
            4'hB: w_seg7 = 7'b0000011;
            4'hC: w_seg7 = 7'b1000110;
            4'hD: w_seg7 = 7'b0100001;
            4'hE: w_seg7 = 7'b0000110;
            4'hF: w_seg7 = 7'b0001110;
            default: w_seg7 = 7'b1111111;
        endcase
    end

    // A disabled digit keeps its slot but leaves all anodes off
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_seg <= 8'hFF;
            r_an  <= 4'hF;
        end else begin
            r_seg <= {~r_dp[r_idx], w_seg7};
            r_an  <= ~({3'b000, r_en[r_idx]} << r_idx);
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_seven_seg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_ahb_lite_seven_seg                                          |
// | Function : self-checking bench for the AHB-Lite seven-segment slave       |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tb_ahb_lite_seven_seg;

    localparam int SCAN = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [7:0]  seg;
    logic [3:0]  an;

    always #5 HCLK = ~HCLK;

    ahb_lite_seven_seg #(
        .SCAN_CYCLES(SCAN),
        .CNT_W      (3)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HREADY   (HREADY),
        .HWDATA   (HWDATA),
        .HRDATA   (HRDATA),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP),
        .seg      (seg),
        .an       (an)
    );

    // Vector: register contents plus the expected seg/an per digit (digit 0 in the low field)
    typedef struct packed {
        logic [31:0] hex;
        logic [31:0] ctrl;
        logic [31:0] exp_seg;
        logic [15:0] exp_an;
    } vec_t;

    typedef struct packed {
        logic        vld;
        logic        wr;
        logic [1:0]  a;
        logic [31:0] wd;
    } ph_t;

    vec_t        vecs [5];
    vec_t        v_rst;
    ph_t         dp;
    logic [31:0] q[$];
    logic [15:0] sh_hex;
    logic [7:0]  sh_ctrl;
    int          rel_cycles = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always @(posedge HCLK) rel_cycles <= HRESETn ? rel_cycles + 1 : 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [1:0] a);
        case (a)
            2'd0:    return {16'h0000, sh_hex};
            2'd1:    return {24'h000000, sh_ctrl};
            default: return 32'h0;
        endcase
    endfunction

    // One bus cycle, entered and left at a falling edge
    task automatic cyc(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd, input logic rdy);
        logic [31:0] exp;
        logic        acc;
        exp = 32'h0;
        if (dp.vld && !dp.wr) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_empty: got no expected entry for a read data phase");
            end else begin
                exp = q.pop_front();
            end
        end
        chk("hrdata", HRDATA, exp);
        chk("hready_hresp", {30'b0, HREADYOUT, HRESP}, 32'h2);
        if (dp.vld && dp.wr) begin
            HWDATA = dp.wd;
            if (dp.a == 2'd0) sh_hex = dp.wd[15:0];
            else if (dp.a == 2'd1) sh_ctrl = dp.wd[7:0];
        end else begin
            HWDATA = 32'hFFFF_FFFF;
        end
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HADDR  = addr;
        HREADY = rdy;
        acc = sel & rdy & trans[1];
        if (acc && !wr) q.push_back(rd_model(addr[3:2]));
        @(posedge HCLK);
        if (rdy) begin
            dp.vld = acc;
            dp.wr  = wr;
            dp.a   = addr[3:2];
            dp.wd  = wd;
        end
        @(negedge HCLK);
    endtask

    task automatic scan_check(input vec_t v, input int ncyc, input string tag);
        for (int k = 0; k < ncyc; k++) begin
            int d;
            d = ((rel_cycles - 1) / SCAN) % 4;
            chk({tag, "_seg"}, {24'h0, seg}, {24'h0, v.exp_seg[d*8 +: 8]});
            chk({tag, "_an"},  {28'h0, an},  {28'h0, v.exp_an[d*4 +: 4]});
            @(posedge HCLK);
            @(negedge HCLK);
        end
    endtask

    initial begin
        v_rst   = '{32'h0000_0000, 32'h0000_000F, 32'hC0C0_C0C0, 16'h7BDE};
        vecs[0] = '{32'h0000_A53F, 32'h0000_000F, 32'h8892_B08E, 16'h7BDE};
        vecs[1] = '{32'h0000_A53F, 32'h0000_0025, 32'h8892_308E, 16'hFBFE};
        vecs[2] = '{32'h0000_8E0D, 32'h0000_00F8, 32'h0006_4021, 16'h7FFF};
        vecs[3] = '{32'h0000_6C24, 32'h0000_0093, 32'h02C6_A419, 16'hFFDE};
        vecs[4] = '{32'h0000_B971, 32'h0000_000F, 32'h8390_F8F9, 16'h7BDE};

        dp      = '0;
        sh_hex  = 16'h0000;
        sh_ctrl = 8'h0F;
        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HADDR   = 32'h0;
        HTRANS  = 2'b00;
        HWRITE  = 1'b0;
        HREADY  = 1'b1;
        HWDATA  = 32'h0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_seg", {24'h0, seg}, 32'hFF);
        chk("rst_an", {28'h0, an}, 32'hF);
        chk("rst_hready_hresp", {30'b0, HREADYOUT, HRESP}, 32'h2);
        chk("rst_hrdata", HRDATA, 32'h0);

        HRESETn = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        scan_check(v_rst, 16, "scan_rst");

        foreach (vecs[i]) begin
            cyc(1'b1, 2'b10, 1'b1, 32'h0, vecs[i].hex, 1'b1);
            cyc(1'b1, 2'b10, 1'b1, 32'h4, vecs[i].ctrl, 1'b1);
            cyc(1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
            cyc(1'b1, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1);
            cyc(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
            cyc(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
            scan_check(vecs[i], 16, $sformatf("scan_v%0d", i));
        end

        // Write immediately followed by a read of the same register
        cyc(1'b1, 2'b10, 1'b1, 32'h0, 32'h0000_1234, 1'b1);
        cyc(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);

        // Transfers that must not be accepted, plus a write to an unused slot
        cyc(1'b1, 2'b00, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1);
        cyc(1'b0, 2'b10, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1);
        cyc(1'b1, 2'b10, 1'b1, 32'h4, 32'hFFFF_FFFF, 1'b0);
        cyc(1'b1, 2'b10, 1'b1, 32'h8, 32'hFFFF_FFFF, 1'b1);
        cyc(1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b1, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1);
        cyc(1'b1, 2'b10, 1'b0, 32'h8, 32'h0, 1'b1);
        cyc(1'b1, 2'b10, 1'b0, 32'hC, 32'h0, 1'b1);
        cyc(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);

        // Reset lands on the data phase of a write
        cyc(1'b1, 2'b10, 1'b1, 32'h0, 32'h0000_BEEF, 1'b1);
        HWDATA  = 32'h0000_BEEF;
        HSEL    = 1'b0;
        HTRANS  = 2'b00;
        HRESETn = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK);
        chk("midrst_seg", {24'h0, seg}, 32'hFF);
        chk("midrst_an", {28'h0, an}, 32'hF);
        dp      = '0;
        sh_hex  = 16'h0000;
        sh_ctrl = 8'h0F;
        HRESETn = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        scan_check(v_rst, 8, "scan_after_rst");
        cyc(1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b1, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1);
        cyc(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);

        chk("sb_drain", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
